button_event: RTL and testbench
===============================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter CLK_PER_MS, default 50000: clocks per 1 ms tick; legal range 1..65536.
REQ-002 Parameter LONG_MS, default 1000: hold time in ms before long-press; legal range 1..65535.
REQ-003 Parameter REPEAT_MS, default 200: auto-repeat period in ms; legal range 1..65535.
REQ-004 clock  input  1  the design has one clock; all state is updated on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 SSW  input  1  debounced switch level from the debounce stage, synchronous to clock; 1 = pressed.
REQ-007 press_p  output  1  one-clock pulse on each accepted press.
REQ-008 release_p  output  1  one-clock pulse on each release of an accepted press.
REQ-009 long_p  output  1  one-clock pulse once per press when the hold reaches LONG_MS.
REQ-010 repeat_p  output  1  one-clock pulse every REPEAT_MS after long_p while the switch is held.
REQ-011 held  output  1  level signal; 1 from the press_p cycle until the release_p cycle, exclusive.
REQ-012 press_cnt  output  8  count of accepted presses.

Function
REQ-013 The block SHALL register SSW into ssw_q; rise = SSW & ~ssw_q, fall = ~SSW & ssw_q.
REQ-014 All outputs SHALL be registered; pulse outputs SHALL be high for exactly one clock.
REQ-015 FSM states: IDLE, PRESSED, LONG; LONG covers both post-long hold and repeat.
REQ-016 IDLE, on rise: go to PRESSED; press_p=1 and held=1 on that same edge (1-clock latency from SSW sampled high); press_cnt+1, wrapping 255->0; clear prescaler and hold_ms.
REQ-017 IDLE SHALL ignore fall.
REQ-018 Prescaler (16-bit) runs only outside IDLE; tick = prescaler==CLK_PER_MS-1, which wraps the prescaler to 0.
REQ-019 PRESSED, on tick: hold_ms+1. When the incremented value equals LONG_MS: long_p=1, go to LONG, clear rep_ms.
REQ-020 LONG, on tick: rep_ms+1. When it equals REPEAT_MS: repeat_p=1, clear rep_ms.
REQ-021 PRESSED/LONG, on fall: release_p=1, held=0, go to IDLE.
REQ-022 Fall takes priority over a coincident tick: no long_p or repeat_p in the release cycle.
REQ-023 Timing: long_p occurs exactly CLK_PER_MS*LONG_MS clocks after press_p; repeat_p follows at every further CLK_PER_MS*REPEAT_MS clocks.
REQ-024 At most one of press_p, release_p, long_p, repeat_p SHALL be high in any cycle.

Reset
REQ-025 On reset assertion, immediately and independent of clock: state=IDLE, outputs=0, press_cnt=0, prescaler/hold_ms/rep_ms=0, ssw_q=1.
REQ-026 A switch already pressed when reset deasserts SHALL produce no events until it is released and pressed again.
REQ-027 Reset asserted mid-hold SHALL produce no release_p.

Configuration
REQ-028 Macro BUTTON_EVENT_REPEAT_EN defined: repeat_p behaves as in REQ-020.
REQ-029 Macro BUTTON_EVENT_REPEAT_EN undefined: rep_ms logic is omitted, repeat_p is tied to 0, and LONG waits only for fall.

Verification (CLK_PER_MS=10, LONG_MS=5, REPEAT_MS=3, macro defined unless stated)
REQ-030 SSW high 30 clocks, then low -> press_p 1 clock after the rise; release_p 1 clock after the fall; no long_p; press_cnt=1; held high 30 clocks.
REQ-031 SSW high 120 clocks -> long_p at press_p+50; repeat_p at +80 and +110; release_p after the fall.
REQ-032 SSW falls on the cycle hold_ms would reach 5 -> release_p only, no long_p, state IDLE.
REQ-033 reset pulsed at press_p+20 while SSW stays high -> all outputs 0, no release_p, no press_p until SSW goes low then high.
REQ-034 256 short presses -> press_cnt wraps to 0; 257th press -> 1.
REQ-035 Macro undefined, SSW high 120 clocks -> long_p at +50, repeat_p never asserted.

Source files
------------

// File: rtl/button_event.sv
`timescale 1ns/1ps
// button_event: turns a debounced switch level into press / release / long-press /
// auto-repeat pulses, a held level and a wrapping press counter.
// Optional feature macro: BUTTON_EVENT_REPEAT_EN enables auto-repeat pulses on repeat_p;
// when undefined, repeat_p is tied low and the LONG state only waits for release.
module button_event #(
    parameter int unsigned CLK_PER_MS = 50000,
    parameter int unsigned LONG_MS    = 1000,
    parameter int unsigned REPEAT_MS  = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       SSW,
    output logic       press_p,
    output logic       release_p,
    output logic       long_p,
    output logic       repeat_p,
    output logic       held,
    output logic [7:0] press_cnt
);

    localparam logic [15:0] TICK_MAX = 16'(CLK_PER_MS - 1);
    localparam logic [15:0] LONG_VAL = 16'(LONG_MS);

    typedef enum logic [1:0] {StIdle, StPressed, StLong} state_t;

    state_t      state;
    logic        ssw_q;
    logic [15:0] prescaler;
    logic [15:0] hold_ms;
    logic [15:0] hold_inc;
    logic        rise;
    logic        fall;
    logic        tick;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [15:0] REP_VAL = 16'(REPEAT_MS);
    logic [15:0] rep_ms;
    logic [15:0] rep_inc;
    assign rep_inc = rep_ms + 16'd1;
`else
    // Repeat period has no effect without the repeat feature.
    logic unused_repeat_ms;
    assign unused_repeat_ms = ^REPEAT_MS;
    assign repeat_p = 1'b0;
`endif

    assign rise     = SSW & ~ssw_q;
    assign fall     = ~SSW & ssw_q;
    assign tick     = (prescaler == TICK_MAX);
    assign hold_inc = hold_ms + 16'd1;

    // Edge detect, ms prescaler and event FSM; every output is registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            // Start "pressed" so a switch held through reset is not seen as a new press.
            ssw_q     <= 1'b1;
            prescaler <= '0;
            hold_ms   <= '0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            long_p    <= 1'b0;
            held      <= 1'b0;
            press_cnt <= '0;
`ifdef BUTTON_EVENT_REPEAT_EN
            rep_ms    <= '0;
            repeat_p  <= 1'b0;
`endif
        end else begin
            ssw_q     <= SSW;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            long_p    <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_p  <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (rise) begin
                        state     <= StPressed;
                        press_p   <= 1'b1;
                        held      <= 1'b1;
                        press_cnt <= press_cnt + 8'd1;
                        prescaler <= '0;
                        hold_ms   <= '0;
                    end
                end
                StPressed: begin
                    // Release wins over a coincident tick.
                    if (fall) begin
                        state     <= StIdle;
                        release_p <= 1'b1;
                        held      <= 1'b0;
                    end else begin
                        prescaler <= tick ? 16'd0 : prescaler + 16'd1;
                        if (tick) begin
                            hold_ms <= hold_inc;
                            if (hold_inc == LONG_VAL) begin
                                state  <= StLong;
                                long_p <= 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
                                rep_ms <= '0;
`endif
                            end
                        end
                    end
                end
                StLong: begin
                    if (fall) begin
                        state     <= StIdle;
                        release_p <= 1'b1;
                        held      <= 1'b0;
                    end else begin
                        prescaler <= tick ? 16'd0 : prescaler + 16'd1;
`ifdef BUTTON_EVENT_REPEAT_EN
                        if (tick) begin
                            if (rep_inc == REP_VAL) begin
                                rep_ms   <= '0;
                                repeat_p <= 1'b1;
                            end else begin
                                rep_ms <= rep_inc;
                            end
                        end
`endif
                    end
                end
                default: begin
                    state <= StIdle;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
`timescale 1ns/1ps
// tb_button_event: directed bench for button_event with CLK_PER_MS=10, LONG_MS=5, REPEAT_MS=3.
module tb_button_event;

    localparam int unsigned CLK_PER_MS = 10;
    localparam int unsigned LONG_MS    = 5;
    localparam int unsigned REPEAT_MS  = 3;
    localparam int LONG_CYC = CLK_PER_MS * LONG_MS;    // 50 clocks
    localparam int REP_CYC  = CLK_PER_MS * REPEAT_MS;  // 30 clocks
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       SSW;
    logic       press_p;
    logic       release_p;
    logic       long_p;
    logic       repeat_p;
    logic       held;
    logic [7:0] press_cnt;

    int vectors = 0;
    int errors  = 0;

    button_event #(
        .CLK_PER_MS(CLK_PER_MS),
        .LONG_MS   (LONG_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .SSW      (SSW),
        .press_p  (press_p),
        .release_p(release_p),
        .long_p   (long_p),
        .repeat_p (repeat_p),
        .held     (held),
        .press_cnt(press_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 1 time unit past the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Packed view {press_p, release_p, long_p, repeat_p, held}.
    function automatic logic [4:0] ev();
        return {press_p, release_p, long_p, repeat_p, held};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Hold SSW high for n clocks, checking every cycle's events, then release.
    task automatic press_hold(input string tag, input int n);
        logic [4:0] expv;
        SSW = 1'b1;
        step();
        check({tag, "/press"}, 32'(ev()), 32'(5'b10001));
        for (int k = 1; k < n; k++) begin
            step();
            expv = 5'b00001;
            if (k == LONG_CYC) expv[2] = 1'b1;
            if (REP_EN && k > LONG_CYC && ((k - LONG_CYC) % REP_CYC) == 0) expv[1] = 1'b1;
            check($sformatf("%s/hold+%0d", tag, k), 32'(ev()), 32'(expv));
        end
        SSW = 1'b0;
        step();
        check({tag, "/release"}, 32'(ev()), 32'(5'b01000));
        step();
        check({tag, "/after"}, 32'(ev()), 32'(5'b00000));
    endtask

    task automatic short_press();
        SSW = 1'b1;
        step();
        step();
        SSW = 1'b0;
        step();
        step();
    endtask

    initial begin
        reset = 1'b0;
        SSW   = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("reset_events", 32'(ev()), 32'(5'b00000));
        check("reset_cnt", 32'(press_cnt), 32'd0);
        step();
        step();
        reset = 1'b0;
        // Post-reset ssw_q=1 and SSW=0 gives a fall in IDLE, which must be ignored.
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("idle+%0d", k), 32'(ev()), 32'(5'b00000));
        end

        // Short press: no long_p, held 30 clocks.
        press_hold("short30", 30);
        check("cnt_after_short", 32'(press_cnt), 32'd1);

        // Long press with repeats.
        press_hold("long120", 120);
        check("cnt_after_long", 32'(press_cnt), 32'd2);

        // Release on the very cycle long_p would fire.
        press_hold("edge50", LONG_CYC);
        check("cnt_after_edge", 32'(press_cnt), 32'd3);
        step();
        check("edge50_idle", 32'(ev()), 32'(5'b00000));

        // Reset in the middle of a hold.
        SSW = 1'b1;
        step();
        check("mid/press", 32'(ev()), 32'(5'b10001));
        for (int k = 0; k < 20; k++) step();
        #1 reset = 1'b1;
        #1;
        check("mid/async_events", 32'(ev()), 32'(5'b00000));
        check("mid/async_cnt", 32'(press_cnt), 32'd0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("mid/held_through+%0d", k), 32'(ev()), 32'(5'b00000));
        end
        SSW = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("mid/let_go+%0d", k), 32'(ev()), 32'(5'b00000));
        end
        press_hold("mid/repress", 30);
        check("mid/cnt", 32'(press_cnt), 32'd1);

        // Counter wrap: 256 presses since reset -> 0, 257th -> 1.
        for (int k = 0; k < 254; k++) short_press();
        check("cnt_255", 32'(press_cnt), 32'd255);
        short_press();
        check("cnt_wrap0", 32'(press_cnt), 32'd0);
        SSW = 1'b1;
        step();
        check("cnt_257_press", 32'(ev()), 32'(5'b10001));
        check("cnt_257", 32'(press_cnt), 32'd1);
        SSW = 1'b0;
        step();
        check("cnt_257_release", 32'(ev()), 32'(5'b01000));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
